// File: rtl/zl_conv_interleaver.sv
// Forney convolutional byte interleaver.
// The commutator position br selects one of I branches per transfer. Branch 0
// passes the symbol straight through. Branch j >= 1 is a circular delay line of
// j*D symbols inside one flat storage array. Each branch has a primed flag that
// forces zeros out until the branch has filled once after reset.
//
// Handshake: data_out_req mirrors data_in_req and data_in_ack mirrors
// data_out_ack, both combinationally. A transfer happens on a rising clk edge
// where data_in_req && data_out_ack. Every transfer consumes one input symbol
// and produces one output symbol. All state holds when there is no transfer.
module zl_conv_interleaver #(
    parameter int I     = 12,
    parameter int D     = 17,
    parameter int M     = 8,
    parameter int BR_W  = 4,
    parameter int PTR_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         data_in_req,
    output logic         data_in_ack,
    input  logic [M-1:0] data_in,
    output logic         data_out_req,
    input  logic         data_out_ack,
    output logic [M-1:0] data_out
);

    localparam int DEPTH  = D * I * (I - 1) / 2;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BR_W-1:0]   br;
    logic [PTR_W-1:0]  ptr [1:I-1];
    logic [I-1:1]      primed;
    logic [M-1:0]      mem [0:DEPTH-1];
    logic              xfer;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_primed;

    assign data_out_req = data_in_req;
    assign data_in_ack  = data_out_ack;
    assign xfer         = data_in_req & data_out_ack;

    // Storage address and primed state of the branch the commutator points at.
    // Branch j's region starts at D*j*(j-1)/2.
    always_comb begin
        cur_addr   = '0;
        cur_primed = 1'b0;
        for (int j = 1; j < I; j++) begin
            if (br == BR_W'(j)) begin
                cur_addr   = ADDR_W'(D * j * (j - 1) / 2) + ADDR_W'(ptr[j]);
                cur_primed = primed[j];
            end
        end
    end

    // Output mux: pass-through on branch 0, otherwise the oldest entry of the
    // branch. Zeros are output until that branch has wrapped once.
    always_comb begin
        data_out = '0;
        if (br == '0) begin
            data_out = data_in;
        end else if (cur_primed) begin
            data_out = mem[cur_addr];
        end
    end

    // Delay-line storage. The read is combinational. The write lands at the
    // edge, so a same-cycle read of that slot still sees the old symbol.
    // Contents are not reset because the primed flags mask them.
    always_ff @(posedge clk) begin
        if (xfer && (br != '0)) begin
            mem[cur_addr] <= data_in;
        end
    end

    // Commutator, per-branch pointers and primed flags. These advance only on a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br     <= '0;
            primed <= '0;
            for (int j = 1; j < I; j++) begin
                ptr[j] <= '0;
            end
        end else if (xfer) begin
            br <= (br == BR_W'(I - 1)) ? '0 : br + BR_W'(1);
            for (int j = 1; j < I; j++) begin
                if (br == BR_W'(j)) begin
                    if (ptr[j] == PTR_W'(j * D - 1)) begin
                        ptr[j]    <= '0;
                        primed[j] <= 1'b1;
                    end else begin
                        ptr[j] <= ptr[j] + PTR_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_zl_conv_interleaver.sv
// Bench for zl_conv_interleaver.
// The reference model stores the input history. At transfer t the commutator
// branch is b = t mod I. The expected output is the input from transfer
// t - b*D*I, or zero if that transfer index is below 0. Branch 0 is pass-through.
module tb_zl_conv_interleaver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance (I=12, D=17, M=8)
    logic       m_req = 1'b0, m_ack = 1'b0;
    logic [7:0] m_din = '0;
    logic       m_in_ack, m_out_req;
    logic [7:0] m_dout;

    zl_conv_interleaver dut (
        .clk(clk), .rst_n(rst_n),
        .data_in_req(m_req), .data_in_ack(m_in_ack), .data_in(m_din),
        .data_out_req(m_out_req), .data_out_ack(m_ack), .data_out(m_dout)
    );

    // Small instance (I=4, D=3, M=4)
    logic       s_req = 1'b0, s_ack = 1'b0;
    logic [3:0] s_din = '0;
    logic       s_in_ack, s_out_req;
    logic [3:0] s_dout;

    zl_conv_interleaver #(.I(4), .D(3), .M(4), .BR_W(2), .PTR_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .data_in_req(s_req), .data_in_ack(s_in_ack), .data_in(s_din),
        .data_out_req(s_out_req), .data_out_ack(s_ack), .data_out(s_dout)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] m_hist[$];
    int         m_t;
    logic [3:0] s_hist[$];
    int         s_t;

    // Scoreboard for replaying the unstalled run
    logic [7:0] stim_q[$];
    logic [7:0] exp_q[$];

    function automatic logic [7:0] exp_main(input logic [7:0] din);
        int b;
        int dly;
        b   = m_t % 12;
        dly = b * 17 * 12;
        if (b == 0) return din;
        if (m_t >= dly) return m_hist[m_t - dly];
        return 8'h00;
    endfunction

    function automatic logic [3:0] exp_small(input logic [3:0] din);
        int b;
        int dly;
        b   = s_t % 4;
        dly = b * 3 * 4;
        if (b == 0) return din;
        if (s_t >= dly) return s_hist[s_t - dly];
        return 4'h0;
    endfunction

    task automatic main_push(input logic [7:0] d);
        m_hist.push_back(d);
        m_t++;
    endtask

    task automatic small_push(input logic [3:0] d);
        s_hist.push_back(d);
        s_t++;
    endtask

    // Drive after the rising edge and return at the falling edge for sampling
    task automatic drive_main(input logic r, input logic a, input logic [7:0] d);
        @(posedge clk);
        #1;
        m_req = r;
        m_ack = a;
        m_din = d;
        @(negedge clk);
    endtask

    task automatic drive_small(input logic r, input logic a, input logic [3:0] d);
        @(posedge clk);
        #1;
        s_req = r;
        s_ack = a;
        s_din = d;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m_req = 1'b0; m_ack = 1'b0; m_din = '0;
        s_req = 1'b0; s_ack = 1'b0; s_din = '0;
        @(negedge clk);
        rst_n = 1'b1;
        m_hist.delete(); m_t = 0;
        s_hist.delete(); s_t = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        drive_main(1'b0, 1'b0, 8'h00);
        checks++;
        if (m_out_req !== 1'b0) begin
            failures++; $display("FAIL reset_out_req got=%b exp=0", m_out_req);
        end
        checks++;
        if (m_in_ack !== 1'b0) begin
            failures++; $display("FAIL reset_in_ack got=%b exp=0", m_in_ack);
        end
        drive_main(1'b0, 1'b1, 8'h00);
        checks++;
        if (m_in_ack !== 1'b1) begin
            failures++; $display("FAIL reset_ack_pass got=%b exp=1", m_in_ack);
        end
        checks++;
        if (m_out_req !== 1'b0) begin
            failures++; $display("FAIL reset_req_idle got=%b exp=0", m_out_req);
        end
        drive_main(1'b1, 1'b1, 8'h47);
        checks++;
        if (m_dout !== 8'h47) begin
            failures++; $display("FAIL reset_first_sync got=%h exp=47", m_dout);
        end
        checks++;
        if (m_out_req !== 1'b1) begin
            failures++; $display("FAIL reset_req_pass got=%b exp=1", m_out_req);
        end
        main_push(8'h47);
        checks++;
        if (s_out_req !== 1'b0) begin
            failures++; $display("FAIL reset_small_req got=%b exp=0", s_out_req);
        end
    endtask

    task automatic run_incrementing();
        logic [7:0] d;
        logic [7:0] e;
        for (int t = 0; t < 2300; t++) begin
            d = 8'(t);
            drive_main(1'b1, 1'b1, d);
            e = exp_main(d);
            checks++;
            if (m_dout !== e) begin
                failures++; $display("FAIL incr_model t=%0d got=%h exp=%h", t, m_dout, e);
            end
            if (t < 204 && (t % 12) != 0) begin
                checks++;
                if (m_dout !== 8'h00) begin
                    failures++; $display("FAIL incr_zero_fill t=%0d got=%h exp=00", t, m_dout);
                end
            end
            if (t == 205) begin
                checks++;
                if (m_dout !== 8'h01) begin
                    failures++; $display("FAIL incr_br1_first got=%h exp=01", m_dout);
                end
            end
            if (t == 2255) begin
                checks++;
                if (m_dout !== 8'h0B) begin
                    failures++; $display("FAIL incr_br11_first got=%h exp=0b", m_dout);
                end
            end
            main_push(d);
        end
    endtask

    task automatic test_incrementing();
        apply_reset();
        run_incrementing();
    endtask

    task automatic test_random_stream();
        logic [7:0] d;
        logic [7:0] e;
        apply_reset();
        stim_q.delete();
        exp_q.delete();
        for (int n = 0; n < 12244; n++) begin
            d = (n < 10000) ? 8'($urandom_range(0, 255)) : 8'h00;
            drive_main(1'b1, 1'b1, d);
            e = exp_main(d);
            checks++;
            if (m_dout !== e) begin
                failures++; $display("FAIL stream n=%0d got=%h exp=%h", n, m_dout, e);
            end
            stim_q.push_back(d);
            exp_q.push_back(e);
            main_push(d);
        end
    endtask

    task automatic test_random_stalls();
        logic       r;
        logic       a;
        logic [7:0] d;
        logic [7:0] e;
        int         cyc;
        apply_reset();
        cyc = 0;
        while (stim_q.size() > 0 && cyc < 60000) begin
            r = ($urandom_range(0, 99) >= 30);
            a = ($urandom_range(0, 99) >= 30);
            d = r ? stim_q[0] : 8'($urandom_range(0, 255));
            drive_main(r, a, d);
            cyc++;
            checks++;
            if (m_out_req !== r || m_in_ack !== a) begin
                failures++;
                $display("FAIL stall_pass req=%b/%b ack=%b/%b", m_out_req, r, m_in_ack, a);
            end
            e = exp_main(d);
            checks++;
            if (m_dout !== e) begin
                failures++; $display("FAIL stall_model cyc=%0d got=%h exp=%h", cyc, m_dout, e);
            end
            if (r && a) begin
                e = exp_q.pop_front();
                checks++;
                if (m_dout !== e) begin
                    failures++; $display("FAIL stall_replay t=%0d got=%h exp=%h", m_t, m_dout, e);
                end
                main_push(stim_q.pop_front());
            end
        end
        checks++;
        if (stim_q.size() != 0) begin
            failures++; $display("FAIL stall_timeout left=%0d exp=0", stim_q.size());
        end
        m_req = 1'b0;
        m_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic [7:0] e;
        apply_reset();
        for (int t = 0; t < 1000; t++) begin
            d = 8'($urandom_range(0, 255));
            drive_main(1'b1, 1'b1, d);
            e = exp_main(d);
            checks++;
            if (m_dout !== e) begin
                failures++; $display("FAIL mid_pre t=%0d got=%h exp=%h", t, m_dout, e);
            end
            main_push(d);
        end
        apply_reset();
        run_incrementing();
    endtask

    task automatic test_param_sweep();
        logic [3:0] d;
        logic [3:0] e;
        apply_reset();
        for (int t = 0; t < 600; t++) begin
            d = (t < 100) ? 4'(t) : 4'($urandom_range(0, 15));
            drive_small(1'b1, 1'b1, d);
            e = exp_small(d);
            checks++;
            if (s_dout !== e) begin
                failures++; $display("FAIL sweep t=%0d got=%h exp=%h", t, s_dout, e);
            end
            if (t == 39) begin
                checks++;
                if (s_dout !== 4'h3) begin
                    failures++; $display("FAIL sweep_br3_first got=%h exp=3", s_dout);
                end
            end
            if (t < 36 && (t % 4) == 3) begin
                checks++;
                if (s_dout !== 4'h0) begin
                    failures++; $display("FAIL sweep_br3_zero t=%0d got=%h exp=0", t, s_dout);
                end
            end
            small_push(d);
        end
        s_req = 1'b0;
        s_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_incrementing();
        test_random_stream();
        test_random_stalls();
        test_reset_mid();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
